bcd2bin_16: RTL and testbench

BCD2BIN_16 -- requirements
Module: bcd2bin_16

---
 rtl/bcd2bin_16.sv | 136 +++++++++++++
 tb/tb_bcd2bin_16.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_16.sv
// Five-digit BCD to 16-bit binary converter using a serial reverse double-dabble.
// One conversion takes 17 clock cycles; the result saturates at 16'hFFFF.
module bcd2bin_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  BCD_0,
  input  logic [3:0]  BCD_1,
  input  logic [3:0]  BCD_2,
  input  logic [3:0]  BCD_3,
  input  logic [3:0]  BCD_4,
  output logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ovf
);

  typedef enum logic [1:0] {StIdle, StShift, StDoneOut} state_e;

  state_e      state_q, state_d;
  logic [19:0] bcd_q, bcd_d;
  logic [16:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        inv_q, inv_d;
  logic [15:0] b_q, b_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic [19:0] bcd_sh, bcd_fix;
  logic [16:0] acc_sh;
  logic [3:0]  digit;
  logic        any_invalid;

  always_comb begin
    any_invalid = (BCD_0 > 4'd9) || (BCD_1 > 4'd9) || (BCD_2 > 4'd9) ||
                  (BCD_3 > 4'd9) || (BCD_4 > 4'd9);

    // One reverse double-dabble step: shift right, then correct each digit >= 8.
    bcd_sh  = {1'b0, bcd_q[19:1]};
    acc_sh  = {bcd_q[0], acc_q[16:1]};
    bcd_fix = bcd_sh;
    digit   = 4'd0;
    for (int i = 0; i < 5; i++) begin
      digit = bcd_sh[4*i +: 4];
      if (digit >= 4'd8) begin
        bcd_fix[4*i +: 4] = digit - 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    b_d     = b_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          bcd_d   = {BCD_4, BCD_3, BCD_2, BCD_1, BCD_0};
          acc_d   = 17'd0;
          cnt_d   = 5'd0;
          inv_d   = any_invalid;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = bcd_fix;
        acc_d = acc_sh;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd16) begin
          state_d = StDoneOut;
        end
      end
      default: state_d = StIdle;
    endcase

    // DONE_OUT is only ever a next-state decode: results load and the FSM
    // lands in IDLE on the same edge, so it never occupies a cycle.
    if (state_d == StDoneOut) begin
      done_d  = 1'b1;
      state_d = StIdle;
      if (inv_q) begin
        err_d = 1'b1;
        ovf_d = 1'b0;
        b_d   = 16'h0000;
      end else if (acc_sh[16]) begin
        err_d = 1'b0;
        ovf_d = 1'b1;
        b_d   = 16'hFFFF;
      end else begin
        err_d = 1'b0;
        ovf_d = 1'b0;
        b_d   = acc_sh[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bcd_q   <= 20'd0;
      acc_q   <= 17'd0;
      cnt_q   <= 5'd0;
      inv_q   <= 1'b0;
      b_q     <= 16'h0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      b_q     <= b_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign B    = b_q;
  assign busy = (state_q == StShift);
  assign done = done_q;
  assign err  = err_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd2bin_16.sv
// Scoreboard bench for bcd2bin_16: directed vectors push expected results,
// a negedge monitor pops and checks them on every done pulse.
module tb_bcd2bin_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  BCD_0, BCD_1, BCD_2, BCD_3, BCD_4;
  logic [15:0] B;
  logic        busy, done, err, ovf;

  typedef struct {
    logic [15:0] b;
    logic        err;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_chk;
  int   n_fail;

  bcd2bin_16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .BCD_0 (BCD_0),
    .BCD_1 (BCD_1),
    .BCD_2 (BCD_2),
    .BCD_3 (BCD_3),
    .BCD_4 (BCD_4),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .ovf   (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, required 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = sb.pop_front();
        chk("result_B", {16'd0, B}, {16'd0, e.b});
        chk("result_err", {31'd0, err}, {31'd0, e.err});
        chk("result_ovf", {31'd0, ovf}, {31'd0, e.ovf});
        chk("done_latency", cyc, e.cyc);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic set_digits(input logic [19:0] v);
    {BCD_4, BCD_3, BCD_2, BCD_1, BCD_0} = v;
  endtask

  // Issue start for one edge; optionally record the expected response.
  task automatic start_conv(input logic [19:0] v, input logic [15:0] eb, input logic e,
                            input logic o, input bit push);
    exp_t x;
    set_digits(v);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      x.b   = eb;
      x.err = e;
      x.ovf = o;
      x.cyc = cyc + 17;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_B"}, {16'd0, B}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    int t;
    cyc    = 0;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    set_digits(20'h00000);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    idle_gap(2);

    start_conv(20'h65535, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    drain();
    start_conv(20'h00000, 16'h0000, 1'b0, 1'b0, 1'b1);
    drain();
    start_conv(20'h65536, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    drain();
    start_conv(20'h99999, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    drain();
    start_conv(20'h00042, 16'h002A, 1'b0, 1'b0, 1'b1);
    drain();
    chk("hold_B", {16'd0, B}, 32'h002A);

    // Inputs change mid-conversion; the captured value must win.
    start_conv(20'h12345, 16'h3039, 1'b0, 1'b0, 1'b1);
    idle_gap(3);
    set_digits(20'h99999);
    drain();

    start_conv(20'h00A00, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain();

    // Start while busy is dropped; only one done pulse may follow.
    start_conv(20'h10000, 16'h2710, 1'b0, 1'b0, 1'b1);
    idle_gap(4);
    set_digits(20'h00001);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignore", {31'd0, busy}, 32'd1);
    drain();
    idle_gap(20);
    chk("hold_after_ignore", {16'd0, B}, 32'h2710);

    // Start during the done cycle starts the next conversion immediately.
    start_conv(20'h00777, 16'h0309, 1'b0, 1'b0, 1'b1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (done !== 1'b1 && t < 30);
    chk("b2b_first_done_seen", {31'd0, done}, 32'd1);
    start_conv(20'h01024, 16'h0400, 1'b0, 1'b0, 1'b1);
    drain();

    start_conv(20'h70000, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    drain();

    // Reset at step 10 aborts with no done pulse.
    start_conv(20'h54321, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("abort");
    idle_gap(25);

    // Reset beats start on the same edge.
    rst   = 1'b1;
    start = 1'b1;
    set_digits(20'h00555);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    idle_gap(1);
    chk("rst_start_busy_later", {31'd0, busy}, 32'd0);
    idle_gap(20);

    start_conv(20'h00100, 16'h0064, 1'b0, 1'b0, 1'b1);
    drain();
    idle_gap(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
